// File: rtl/fifo_pkg.sv
// Shared definitions for the flagged FIFO: default geometry, thresholds and a width helper.
package fifo_pkg;

  localparam int unsigned DEF_AWIDTH    = 8;
  localparam int unsigned DEF_DWIDTH    = 5;
  localparam int unsigned DEF_DEPTH     = 1 << DEF_AWIDTH;
  localparam int unsigned DEF_AFULL_TH  = DEF_DEPTH - 4;
  localparam int unsigned DEF_AEMPTY_TH = 4;

  // Occupancy needs one more bit than the address so that DEPTH itself is representable
  typedef logic [DEF_AWIDTH:0] count_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_flagged_if.sv
// Producer/consumer-facing signal bundle of the flagged FIFO.
interface fifo_flagged_if
  import fifo_pkg::*;
#(
  parameter int unsigned AWIDTH = DEF_AWIDTH,
  parameter int unsigned DWIDTH = DEF_DWIDTH
);

  logic [DWIDTH-1:0] data_in;
  logic              wr_en;
  logic              rd_en;
  logic              clr_err;
  logic [DWIDTH-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AWIDTH:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output data_in, wr_en, rd_en, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  data_in, wr_en, rd_en, clr_err,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and status-flag control for the flagged FIFO; all flags follow next-cycle count.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned AWIDTH    = DEF_AWIDTH,
  parameter int unsigned AFULL_TH  = (1 << AWIDTH) - 4,
  parameter int unsigned AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              wr_acc,
  output logic              rd_acc,
  output logic [AWIDTH-1:0] wr_ptr,
  output logic [AWIDTH-1:0] rd_ptr,
  output logic [AWIDTH:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam logic [AWIDTH:0] DEPTH_C = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] AF_C    = AFULL_TH[AWIDTH:0];
  localparam logic [AWIDTH:0] AE_C    = AEMPTY_TH[AWIDTH:0];

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;

  always_comb begin
    // Accepts are masked during reset so a reset cycle never touches storage
    rd_acc   = rd_en & ~empty_q & ~rst;
    wr_acc   = wr_en & ~rst & (~full_q | rd_acc);
    wr_ptr_d = wr_ptr_q + AWIDTH'(wr_acc);
    rd_ptr_d = rd_ptr_q + AWIDTH'(rd_acc);
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  assign wr_ptr       = wr_ptr_q;
  assign rd_ptr       = rd_ptr_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;

endmodule

// File: rtl/fifo_flagged.sv
// Single-clock FIFO with programmable thresholds, sticky error flags and selectable FWFT read mode.
module fifo_flagged
  import fifo_pkg::*;
#(
  parameter int unsigned AWIDTH    = DEF_AWIDTH,
  parameter int unsigned DWIDTH    = DEF_DWIDTH,
  parameter int unsigned AFULL_TH  = (1 << AWIDTH) - 4,
  parameter int unsigned AEMPTY_TH = DEF_AEMPTY_TH,
  parameter int unsigned FWFT      = 0
) (
  input  logic           clk,
  input  logic           rst,
  fifo_flagged_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic              wr_acc;
  logic              rd_acc;
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] head;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  fifo_ptr_ctrl #(
    .AWIDTH    (AWIDTH),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) u_ptr_ctrl (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (bus.wr_en),
    .rd_en        (bus.rd_en),
    .wr_acc       (wr_acc),
    .rd_acc       (rd_acc),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (bus.count),
    .full         (bus.full),
    .empty        (bus.empty),
    .almost_full  (bus.almost_full),
    .almost_empty (bus.almost_empty)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr] <= bus.data_in;
  end

  // Asynchronous read: a same-cycle write to this slot is seen only after the edge
  assign head = mem_q[rd_ptr];

  always_comb begin
    dout_d = dout_q;
    if (rd_acc) dout_d = head;
    ovf_d = (bus.wr_en & ~wr_acc) | (ovf_q & ~bus.clr_err);
    udf_d = (bus.rd_en & bus.empty) | (udf_q & ~bus.clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  assign bus.data_out  = (FWFT != 0) ? head : dout_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;

endmodule

// File: tb/tb_fifo_flagged.sv
// Scoreboard bench: a queue-based model drives expectations for a registered-read and an FWFT instance.
module tb_fifo_flagged;
  import fifo_pkg::*;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 5;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AF    = 252;
  localparam int unsigned AE    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_flagged_if #(.AWIDTH(AW), .DWIDTH(DW)) bus0 ();
  fifo_flagged_if #(.AWIDTH(AW), .DWIDTH(DW)) bus1 ();

  assign bus1.data_in = bus0.data_in;
  assign bus1.wr_en   = bus0.wr_en;
  assign bus1.rd_en   = bus0.rd_en;
  assign bus1.clr_err = bus0.clr_err;

  fifo_flagged #(.AWIDTH(AW), .DWIDTH(DW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fifo_flagged #(.AWIDTH(AW), .DWIDTH(DW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    count_t        count;
    logic          full, empty, af, ae, ovf, udf;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    bit            d1_valid;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  logic [DW-1:0] mq[$];
  bit            m_ovf, m_udf;
  logic [DW-1:0] m_d0;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exv);
    end
  endtask

  task automatic cmp_status(string tag, count_t cnt, logic f, logic em, logic af,
                            logic ae, logic ov, logic ud);
    chk({tag, ".count"},        32'(cnt), 32'(cur.count));
    chk({tag, ".full"},         32'(f),   32'(cur.full));
    chk({tag, ".empty"},        32'(em),  32'(cur.empty));
    chk({tag, ".almost_full"},  32'(af),  32'(cur.af));
    chk({tag, ".almost_empty"}, 32'(ae),  32'(cur.ae));
    chk({tag, ".overflow"},     32'(ov),  32'(cur.ovf));
    chk({tag, ".underflow"},    32'(ud),  32'(cur.udf));
  endtask

  // Monitor: each expectation describes the state after the next rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        cmp_status("reg", bus0.count, bus0.full, bus0.empty, bus0.almost_full,
                   bus0.almost_empty, bus0.overflow, bus0.underflow);
        cmp_status("fwft", bus1.count, bus1.full, bus1.empty, bus1.almost_full,
                   bus1.almost_empty, bus1.overflow, bus1.underflow);
        chk("reg.data_out", 32'(bus0.data_out), 32'(cur.d0));
        if (cur.d1_valid) chk("fwft.data_out", 32'(bus1.data_out), 32'(cur.d1));
      end
    end
  end

  task automatic step(bit r, bit w, bit rd, bit c, logic [DW-1:0] d);
    exp_t e;
    int unsigned n;
    bit rd_acc, wr_acc;
    @(negedge clk);
    rst          = r;
    bus0.wr_en   = w;
    bus0.rd_en   = rd;
    bus0.clr_err = c;
    bus0.data_in = d;
    if (r) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
      m_d0  = '0;
    end else begin
      n      = mq.size();
      rd_acc = rd && (n > 0);
      wr_acc = w && ((n < DEPTH) || rd_acc);
      if (rd_acc) m_d0 = mq.pop_front();
      if (wr_acc) mq.push_back(d);
      m_ovf = (w && !wr_acc) || (m_ovf && !c);
      m_udf = (rd && (n == 0)) || (m_udf && !c);
    end
    n          = mq.size();
    e.count    = count_t'(n);
    e.full     = (n == DEPTH);
    e.empty    = (n == 0);
    e.af       = (n >= AF);
    e.ae       = (n <= AE);
    e.ovf      = m_ovf;
    e.udf      = m_udf;
    e.d0       = m_d0;
    e.d1_valid = (n > 0);
    e.d1       = (n > 0) ? mq[0] : '0;
    exp_q.push_back(e);
  endtask

  initial begin
    int unsigned pw, pr;
    bus0.wr_en = 0; bus0.rd_en = 0; bus0.clr_err = 0; bus0.data_in = '0;
    m_ovf = 0; m_udf = 0; m_d0 = '0;

    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);

    // Single word in and out
    step(0, 1, 0, 0, 5'h1F);
    step(0, 0, 1, 0, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);

    // Fill with decrementing data, then one write too many
    for (int i = 0; i < int'(DEPTH); i++) step(0, 1, 0, 0, DW'(255 - i));
    step(0, 1, 0, 0, 5'h07);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 0, '0);

    // Full with simultaneous read and write
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, DW'($urandom));
    step(0, 0, 0, 0, '0);

    // Drain completely
    for (int i = 0; i < int'(DEPTH); i++) step(0, 0, 1, 0, '0);

    // Underflow cases
    step(0, 0, 1, 0, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, '0);
    step(0, 1, 1, 0, 5'h03);
    step(0, 0, 1, 0, '0);
    step(0, 0, 1, 1, '0);
    step(0, 0, 0, 0, '0);

    // Head visibility in fall-through mode
    step(0, 0, 0, 1, '0);
    step(0, 1, 0, 0, 5'h0A);
    step(0, 1, 0, 0, 5'h0B);
    step(0, 0, 0, 0, '0);
    step(0, 0, 1, 0, '0);
    step(0, 0, 0, 0, '0);

    // Reset in the middle of traffic, with a write pending
    step(1, 0, 0, 0, '0);
    for (int i = 0; i < 100; i++) step(0, 1, 0, 0, DW'($urandom));
    step(0, 0, 1, 1, '0);
    step(1, 1, 0, 0, 5'h15);
    step(0, 0, 0, 0, '0);

    // Randomised phases with varying read/write bias
    for (int ph = 0; ph < 15; ph++) begin
      pw = $urandom_range(95, 5);
      pr = $urandom_range(95, 5);
      for (int i = 0; i < 200; i++) begin
        step(($urandom_range(999) == 0),
             ($urandom_range(99) < pw),
             ($urandom_range(99) < pr),
             ($urandom_range(15) == 0),
             DW'($urandom));
      end
    end
    step(0, 0, 0, 0, '0);

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
